// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers per-position digits from a multiplexed 7-segment bus.
// Optional macro SEG7_BLANK_DETECT_EN: treat all-off pattern 7F as a legal blank digit (F).
module seg7_scan_reader #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            iSeg,
    input  logic [DIGITS-1:0]     iAn,
    output logic [4*DIGITS-1:0]   oData,
    output logic [DIGITS-1:0]     oValid,
    output logic [DIGITS-1:0]     oErr,
    output logic                  oUpdate
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    logic [6:0]          seg_m, s_seg, prev_seg;
    logic [DIGITS-1:0]   an_m, s_an, prev_an;
    logic [DIGITS-1:0]   an_low;
    logic [CW-1:0]       cnt, cnt_n;
    logic                acc, acc_n;
    logic                qual, same;
    logic [4:0]          dec;
    logic [4*DIGITS-1:0] data_n;
    logic [DIGITS-1:0]   valid_n, err_n;

    // {legal, digit} for a synchronised segment pattern
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b1, 4'd0};
            7'h79:   r = {1'b1, 4'd1};
            7'h24:   r = {1'b1, 4'd2};
            7'h30:   r = {1'b1, 4'd3};
            7'h19:   r = {1'b1, 4'd4};
            7'h12:   r = {1'b1, 4'd5};
            7'h02:   r = {1'b1, 4'd6};
            7'h78:   r = {1'b1, 4'd7};
            7'h00:   r = {1'b1, 4'd8};
            7'h10:   r = {1'b1, 4'd9};
`ifdef SEG7_BLANK_DETECT_EN
            7'h7F:   r = {1'b1, 4'hF};
`endif
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    assign an_low = ~s_an;

    // Qualification and next stability count / accept strobe
    always_comb begin
        qual  = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
        same  = (s_seg == prev_seg) && (s_an == prev_an);
        cnt_n = '0;
        acc_n = 1'b0;
        if (qual) begin
            if (same)
                cnt_n = (cnt == SAT) ? SAT : cnt + CW'(1);
            else
                cnt_n = CW'(1);
            acc_n = (cnt_n == SAT) && (!same || cnt != SAT);
        end
    end

    // Two-flop synchronisers plus the stability tracker state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m    <= '0;
            s_seg    <= '0;
            an_m     <= '0;
            s_an     <= '0;
            prev_seg <= '0;
            prev_an  <= '0;
            cnt      <= '0;
            acc      <= 1'b0;
        end else begin
            seg_m <= iSeg;
            s_seg <= seg_m;
            an_m  <= iAn;
            s_an  <= an_m;
            if (qual && !same) begin
                prev_seg <= s_seg;
                prev_an  <= s_an;
            end
            cnt <= cnt_n;
            acc <= acc_n;
        end
    end

    // Apply an accepted pattern to the position whose anode was low
    always_comb begin
        dec     = decode(prev_seg);
        data_n  = oData;
        valid_n = oValid;
        err_n   = oErr;
        if (acc) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (!prev_an[k]) begin
                    if (dec[4]) begin
                        data_n[4*k +: 4] = dec[3:0];
                        valid_n[k]       = 1'b1;
                    end else begin
                        err_n[k] = 1'b1;
                    end
                end
            end
        end
    end

    // Registered outputs; update pulse only on a real change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oData   <= '0;
            oValid  <= '0;
            oErr    <= '0;
            oUpdate <= 1'b0;
        end else begin
            oData   <= data_n;
            oValid  <= valid_n;
            oErr    <= err_n;
            oUpdate <= (data_n != oData) || (valid_n != oValid) ||
                       (err_n != oErr);
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed table-driven bench for seg7_scan_reader.
// Honours SEG7_BLANK_DETECT_EN for blank-pattern expectations.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  iSeg = 7'h7F;
    logic [3:0]  iAn = 4'hF;
    logic [15:0] oData;
    logic [3:0]  oValid;
    logic [3:0]  oErr;
    logic        oUpdate;

    int errors = 0;
    int checks = 0;
    int upd = 0;
    int base;

`ifdef SEG7_BLANK_DETECT_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          dwell;
        logic [15:0] data;
        logic [3:0]  valid;
        logic [3:0]  err;
        int          pulses;
    } vec_t;

    vec_t tbl [13];

    seg7_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iSeg    (iSeg),
        .iAn     (iAn),
        .oData   (oData),
        .oValid  (oValid),
        .oErr    (oErr),
        .oUpdate (oUpdate)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (oUpdate) upd = upd + 1;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'hE, 7'h79, 10, 16'h0001, 4'h1, 4'h0, 1};
        tbl[1]  = '{4'hD, 7'h24, 10, 16'h0021, 4'h3, 4'h0, 1};
        tbl[2]  = '{4'hB, 7'h30, 10, 16'h0321, 4'h7, 4'h0, 1};
        tbl[3]  = '{4'h7, 7'h19, 10, 16'h4321, 4'hF, 4'h0, 1};
        tbl[4]  = '{4'hE, 7'h79, 10, 16'h4321, 4'hF, 4'h0, 0};
        tbl[5]  = '{4'hD, 7'h24, 10, 16'h4321, 4'hF, 4'h0, 0};
        tbl[6]  = '{4'hB, 7'h30, 10, 16'h4321, 4'hF, 4'h0, 0};
        tbl[7]  = '{4'h7, 7'h19, 10, 16'h4321, 4'hF, 4'h0, 0};
        tbl[8]  = '{4'hC, 7'h40, 20, 16'h4321, 4'hF, 4'h0, 0};
        tbl[9]  = '{4'hE, 7'h40, 3,  16'h4321, 4'hF, 4'h0, 0};
        tbl[10] = '{4'hC, 7'h40, 10, 16'h4321, 4'hF, 4'h0, 0};
        tbl[11] = '{4'hB, 7'h7F, 8,
                    BLANK ? 16'h4F21 : 16'h4321, 4'hF,
                    BLANK ? 4'h0 : 4'h4, 1};
        tbl[12] = '{4'hD, 7'h7E, 8,
                    BLANK ? 16'h4F21 : 16'h4321, 4'hF,
                    BLANK ? 4'h2 : 4'h6, 1};

        // reset state
        cyc(3);
        chk("rst_data", 32'(oData), 0);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_upd", 32'(oUpdate), 0);
        rst_n = 1'b1;
        cyc(2);
        chk("post_rst_data", 32'(oData), 0);
        chk("post_rst_err", 32'(oErr), 0);

        // single digit latency
        base = upd;
        iAn  = 4'hE;
        iSeg = 7'h24;
        cyc(6);
        chk("lat_early_data", 32'(oData), 0);
        chk("lat_early_upd", 32'(oUpdate), 0);
        cyc(1);
        chk("lat_data", 32'(oData), 32'h2);
        chk("lat_valid", 32'(oValid), 32'h1);
        chk("lat_upd", 32'(oUpdate), 1);
        cyc(1);
        chk("lat_upd_end", 32'(oUpdate), 0);
        chk("lat_pulses", 32'(upd - base), 1);

        // scan table
        for (int i = 0; i < 13; i++) begin
            base = upd;
            iAn  = tbl[i].an;
            iSeg = tbl[i].seg;
            cyc(tbl[i].dwell);
            chk($sformatf("v%0d_data", i), 32'(oData), 32'(tbl[i].data));
            chk($sformatf("v%0d_valid", i), 32'(oValid), 32'(tbl[i].valid));
            chk($sformatf("v%0d_err", i), 32'(oErr), 32'(tbl[i].err));
            chk($sformatf("v%0d_pulses", i), 32'(upd - base),
                32'(tbl[i].pulses));
        end

        // toggling pattern never settles
        base = upd;
        iAn  = 4'h7;
        for (int j = 0; j < 8; j++) begin
            iSeg = (j % 2 == 0) ? 7'h79 : 7'h40;
            cyc(2);
        end
        chk("tog_data", 32'(oData), BLANK ? 32'h4F21 : 32'h4321);
        chk("tog_pulses", 32'(upd - base), 0);
        iSeg = 7'h79;
        cyc(6);
        chk("hold_early", 32'(oData[15:12]), 32'h4);
        cyc(1);
        chk("hold_data", 32'(oData), BLANK ? 32'h1F21 : 32'h1321);
        cyc(1);
        chk("hold_pulses", 32'(upd - base), 1);

        // async reset mid-count discards progress
        iAn  = 4'hE;
        iSeg = 7'h12;
        cyc(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(oData), 0);
        chk("arst_valid", 32'(oValid), 0);
        chk("arst_err", 32'(oErr), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("rel_data", 32'(oData), 0);
        chk("rel_valid", 32'(oValid), 0);
        cyc(4);
        chk("rel_early", 32'(oData), 0);
        cyc(1);
        chk("rel_accept", 32'(oData), 32'h5);
        chk("rel_vld", 32'(oValid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
